board_store_ctrl: RTL and testbench

//  Owns the 64-square chess board store (4 bits/square) and sequences every write to it.

---
 rtl/board_store_ctrl_if.sv | 38 +++
 rtl/board_store_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_board_store_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_store_ctrl_if.sv
// board_store_ctrl_if
//   Request/response bundle between chess_logic (master), the board store
//   controller (slave) and display_interface (reads the flat board).
//
//   master drives : init_req, move_req, move_src, move_dst, undo_req, rd_addr
//   slave drives  : rd_piece, move_ack, captured, busy, done, undo_valid, board
//
//   Square address = {row[2:0], col[2:0]}; square code = {color, piece[2:0]}.
//   board holds square i at [PIECE_W*i +: PIECE_W].
interface board_store_ctrl_if #(
    parameter int SQUARES = 64,
    parameter int ADDR_W  = 6,
    parameter int PIECE_W = 4
);
    logic                       init_req;
    logic                       move_req;
    logic [ADDR_W-1:0]          move_src;
    logic [ADDR_W-1:0]          move_dst;
    logic                       undo_req;
    logic [ADDR_W-1:0]          rd_addr;
    logic [PIECE_W-1:0]         rd_piece;
    logic                       move_ack;
    logic [PIECE_W-1:0]         captured;
    logic                       busy;
    logic                       done;
    logic                       undo_valid;
    logic [SQUARES*PIECE_W-1:0] board;

    modport master (
        output init_req, move_req, move_src, move_dst, undo_req, rd_addr,
        input  rd_piece, move_ack, captured, busy, done, undo_valid, board
    );

    modport slave (
        input  init_req, move_req, move_src, move_dst, undo_req, rd_addr,
        output rd_piece, move_ack, captured, busy, done, undo_valid, board
    );
endinterface

// File: rtl/board_store_ctrl.sv
// board_store_ctrl
//   Owns the 64-square chess board store (4 bits per square) and sequences
//   every write to it, one square per clock:
//     - start-position load (64 cycles)
//     - move commit (write dst, then clear src)
//     - optional single-level undo of the last move
//
//   Ports
//     clk  : game logic clock, single domain
//     rst  : asynchronous active-high reset
//     bus  : board_store_ctrl_if.slave (requests in; read data, status,
//            pulses and the flat board out)
//
//   Configuration macro
//     BOARD_UNDO_EN : when defined, builds the undo record and the UN_SRC /
//                     UN_DST states. When undefined, undo_req is ignored and
//                     undo_valid is tied low.
module board_store_ctrl #(
    parameter int SQUARES = 64,
    parameter int ADDR_W  = 6,
    parameter int PIECE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    board_store_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MV_DST,
        MV_SRC
`ifdef BOARD_UNDO_EN
        ,
        UN_SRC,
        UN_DST
`endif
    } state_t;

    state_t              state_q;
    state_t              state_nxt;

    logic [PIECE_W-1:0]  board_q [SQUARES];
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [PIECE_W-1:0]  captured_q;
    logic [PIECE_W-1:0]  rd_piece_q;
    logic                move_ack_q;
    logic                done_q;

    // Decoded per-cycle actions from the FSM
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [PIECE_W-1:0]  wr_data;
    logic                take_move;
    logic                cap_en;
    logic                done_nxt;

`ifdef BOARD_UNDO_EN
    logic [ADDR_W-1:0]   un_src_q;
    logic [ADDR_W-1:0]   un_dst_q;
    logic [PIECE_W-1:0]  un_moved_q;
    logic [PIECE_W-1:0]  un_cap_q;
    logic                undo_valid_q;
    logic                rec_en;
    logic                undo_clr;
`endif

    // Back-rank piece for a column, color bit excluded: R N B Q K B N R
    function automatic logic [2:0] back_rank(input logic [2:0] col);
        logic [2:0] p;
        case (col)
            3'd0, 3'd7: p = 3'b100;
            3'd1, 3'd6: p = 3'b010;
            3'd2, 3'd5: p = 3'b011;
            3'd3:       p = 3'b101;
            default:    p = 3'b110;
        endcase
        return p;
    endfunction

    // Start-position code for a square; row 0/1 black, row 6/7 white
    function automatic logic [PIECE_W-1:0] start_code(input logic [ADDR_W-1:0] sq);
        logic [PIECE_W-1:0] c;
        case (sq[5:3])
            3'd0:    c = {1'b1, back_rank(sq[2:0])};
            3'd1:    c = 4'b1001;
            3'd6:    c = 4'b0001;
            3'd7:    c = {1'b0, back_rank(sq[2:0])};
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state and per-cycle actions
    always_comb begin
        state_nxt = state_q;
        wr_en     = 1'b0;
        wr_addr   = cnt_q;
        wr_data   = '0;
        take_move = 1'b0;
        cap_en    = 1'b0;
        done_nxt  = 1'b0;
`ifdef BOARD_UNDO_EN
        rec_en    = 1'b0;
        undo_clr  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Fixed priority; losing and out-of-IDLE requests are dropped
                if (bus.init_req) begin
                    state_nxt = INIT;
`ifdef BOARD_UNDO_EN
                    undo_clr  = 1'b1;
                end else if (bus.undo_req && undo_valid_q) begin
                    state_nxt = UN_SRC;
`endif
                end else if (bus.move_req) begin
                    state_nxt = MV_DST;
                    take_move = 1'b1;
                end
            end
            INIT: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = start_code(cnt_q);
                if (cnt_q == ADDR_W'(SQUARES - 1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            MV_DST: begin
                // A null move (src == dst) touches nothing and finishes here
                if (src_q != dst_q) begin
                    wr_en     = 1'b1;
                    wr_addr   = dst_q;
                    wr_data   = board_q[src_q];
                    cap_en    = 1'b1;
`ifdef BOARD_UNDO_EN
                    rec_en    = 1'b1;
`endif
                    state_nxt = MV_SRC;
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            MV_SRC: begin
                wr_en     = 1'b1;
                wr_addr   = src_q;
                wr_data   = '0;
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
`ifdef BOARD_UNDO_EN
            UN_SRC: begin
                wr_en     = 1'b1;
                wr_addr   = un_src_q;
                wr_data   = un_moved_q;
                state_nxt = UN_DST;
            end
            UN_DST: begin
                wr_en     = 1'b1;
                wr_addr   = un_dst_q;
                wr_data   = un_cap_q;
                undo_clr  = 1'b1;
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Board store, read port, latched move and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SQUARES; i++) begin
                board_q[i] <= '0;
            end
            cnt_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            captured_q <= '0;
            rd_piece_q <= '0;
            move_ack_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (wr_en) begin
                board_q[wr_addr] <= wr_data;
            end
            // Counter only advances inside INIT, so it always starts at 0
            cnt_q      <= (state_q == INIT) ? cnt_q + ADDR_W'(1) : '0;
            if (take_move) begin
                src_q <= bus.move_src;
                dst_q <= bus.move_dst;
            end
            if (cap_en) begin
                captured_q <= board_q[dst_q];
            end
            // Non-blocking read gives the pre-write value on a same-square write
            rd_piece_q <= board_q[bus.rd_addr];
            move_ack_q <= take_move;
            done_q     <= done_nxt;
        end
    end

`ifdef BOARD_UNDO_EN
    // Single-level undo record, captured alongside the dst write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            un_src_q     <= '0;
            un_dst_q     <= '0;
            un_moved_q   <= '0;
            un_cap_q     <= '0;
            undo_valid_q <= 1'b0;
        end else begin
            if (rec_en) begin
                un_src_q     <= src_q;
                un_dst_q     <= dst_q;
                un_moved_q   <= board_q[src_q];
                un_cap_q     <= board_q[dst_q];
                undo_valid_q <= 1'b1;
            end else if (undo_clr) begin
                undo_valid_q <= 1'b0;
            end
        end
    end

    assign bus.undo_valid = undo_valid_q;
`else
    logic unused_undo_req;
    assign unused_undo_req = bus.undo_req;
    assign bus.undo_valid  = 1'b0;
`endif

    // Flat board view, square g at [PIECE_W*g +: PIECE_W]
    for (genvar g = 0; g < SQUARES; g++) begin : g_flat
        assign bus.board[g*PIECE_W +: PIECE_W] = board_q[g];
    end

    assign bus.rd_piece = rd_piece_q;
    assign bus.move_ack = move_ack_q;
    assign bus.captured = captured_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_board_store_ctrl.sv
// tb_board_store_ctrl
//   Directed self-checking bench for board_store_ctrl. Undo checks follow
//   whether BOARD_UNDO_EN is defined for the build.
module tb_board_store_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

`ifdef BOARD_UNDO_EN
    localparam bit UNDO_ON = 1'b1;
`else
    localparam bit UNDO_ON = 1'b0;
`endif

    board_store_ctrl_if #(.SQUARES(64), .ADDR_W(6), .PIECE_W(4)) bus ();

    board_store_ctrl #(.SQUARES(64), .ADDR_W(6), .PIECE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [255:0] brd;
    assign brd = bus.board;

    function automatic logic [3:0] sq(input int a);
        return brd[a*4 +: 4];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.init_req = 1'b0;
        bus.move_req = 1'b0;
        bus.undo_req = 1'b0;
        bus.move_src = '0;
        bus.move_dst = '0;
        bus.rd_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.board !== 256'd0) begin
            bad++; $display("FAIL reset_board actual=%h required=0", bus.board);
        end
        total++;
        if ({bus.busy, bus.done, bus.move_ack, bus.undo_valid} !== 4'b0000) begin
            bad++; $display("FAIL reset_status actual=%b required=0000",
                            {bus.busy, bus.done, bus.move_ack, bus.undo_valid});
        end
        total++;
        if ({bus.rd_piece, bus.captured} !== 8'h00) begin
            bad++; $display("FAIL reset_data actual=%h required=00", {bus.rd_piece, bus.captured});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_init();
        int n;
        bit done_early;
        bus.init_req = 1'b1;
        step();
        bus.init_req = 1'b0;
        n = 0;
        done_early = 1'b0;
        while (bus.busy && n < 200) begin
            if (bus.done) done_early = 1'b1;
            n++;
            step();
        end
        total++;
        if (n !== 64) begin
            bad++; $display("FAIL init_busy_cycles actual=%0d required=64", n);
        end
        total++;
        if (bus.done !== 1'b1 || done_early) begin
            bad++; $display("FAIL init_done actual=%b early=%b required=1/0", bus.done, done_early);
        end
        total++;
        if ({sq(0), sq(4), sq(12), sq(60), sq(63)} !== 20'b1100_1110_1001_0110_0100) begin
            bad++; $display("FAIL init_squares actual=%b required=11001110100101100100",
                            {sq(0), sq(4), sq(12), sq(60), sq(63)});
        end
        total++;
        if ({sq(3), sq(20), sq(43), sq(48), sq(57)} !== 20'b1101_0000_0000_0001_0010) begin
            bad++; $display("FAIL init_squares2 actual=%b required=11010000000000010010",
                            {sq(3), sq(20), sq(43), sq(48), sq(57)});
        end
        step();
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL init_done_pulse actual=%b required=0", bus.done);
        end
        bus.rd_addr = 6'd4;
        step();
        total++;
        if (bus.rd_piece !== 4'b1110) begin
            bad++; $display("FAIL rd_piece_4 actual=%b required=1110", bus.rd_piece);
        end
    endtask

    task automatic test_move();
        bus.move_src = 6'd52;
        bus.move_dst = 6'd36;
        bus.move_req = 1'b1;
        step();
        bus.move_req = 1'b0;
        total++;
        if ({bus.move_ack, bus.busy, bus.done} !== 3'b110) begin
            bad++; $display("FAIL move_ack actual=%b required=110", {bus.move_ack, bus.busy, bus.done});
        end
        step();
        total++;
        if ({bus.move_ack, bus.busy, bus.done} !== 3'b010) begin
            bad++; $display("FAIL move_second actual=%b required=010", {bus.move_ack, bus.busy, bus.done});
        end
        step();
        total++;
        if ({bus.busy, bus.done} !== 2'b01) begin
            bad++; $display("FAIL move_done actual=%b required=01", {bus.busy, bus.done});
        end
        total++;
        if ({sq(36), sq(52), bus.captured} !== 12'b0001_0000_0000) begin
            bad++; $display("FAIL move_result actual=%b required=000100000000",
                            {sq(36), sq(52), bus.captured});
        end
        total++;
        if (bus.undo_valid !== UNDO_ON) begin
            bad++; $display("FAIL move_undo_valid actual=%b required=%b", bus.undo_valid, UNDO_ON);
        end
        step();
    endtask

    task automatic test_capture();
        bus.rd_addr  = 6'd3;
        bus.move_src = 6'd59;
        bus.move_dst = 6'd3;
        bus.move_req = 1'b1;
        step();
        bus.move_req = 1'b0;
        total++;
        if (bus.move_ack !== 1'b1) begin
            bad++; $display("FAIL cap_ack actual=%b required=1", bus.move_ack);
        end
        step();
        // dst write just happened; registered read must still show the old code
        total++;
        if ({bus.rd_piece, sq(3)} !== 8'b1101_0101) begin
            bad++; $display("FAIL cap_read_during_write actual=%b required=11010101",
                            {bus.rd_piece, sq(3)});
        end
        step();
        total++;
        if ({bus.done, sq(3), sq(59), bus.captured, bus.rd_piece} !== 17'b1_0101_0000_1101_0101) begin
            bad++; $display("FAIL cap_result actual=%b required=10101000011010101",
                            {bus.done, sq(3), sq(59), bus.captured, bus.rd_piece});
        end
        step();
    endtask

    task automatic test_undo();
        int n;
        bit busy_seen;
        bus.undo_req = 1'b1;
        step();
        bus.undo_req = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin
            n++;
            step();
        end
        if (UNDO_ON) begin
            total++;
            if (n !== 2 || bus.done !== 1'b1) begin
                bad++; $display("FAIL undo_seq busy=%0d done=%b required=2/1", n, bus.done);
            end
            total++;
            if ({sq(59), sq(3), bus.undo_valid} !== 9'b0101_1101_0) begin
                bad++; $display("FAIL undo_result actual=%b required=010111010",
                                {sq(59), sq(3), bus.undo_valid});
            end
        end else begin
            total++;
            if (n !== 0 || bus.undo_valid !== 1'b0 || sq(3) !== 4'b0101) begin
                bad++; $display("FAIL undo_ignored busy=%0d uv=%b sq3=%b required=0/0/0101",
                                n, bus.undo_valid, sq(3));
            end
        end
        step();
        bus.undo_req = 1'b1;
        step();
        bus.undo_req = 1'b0;
        busy_seen = bus.busy;
        repeat (3) begin
            step();
            if (bus.busy) busy_seen = 1'b1;
        end
        total++;
        if (busy_seen !== 1'b0) begin
            bad++; $display("FAIL undo_second actual_busy=%b required=0", busy_seen);
        end
    endtask

    task automatic test_priority();
        int n;
        int acks;
        logic [255:0] snap;
        bus.move_src = 6'd52;
        bus.move_dst = 6'd44;
        bus.init_req = 1'b1;
        bus.move_req = 1'b1;
        step();
        bus.init_req = 1'b0;
        bus.move_req = 1'b0;
        n = 0;
        acks = 0;
        while (bus.busy && n < 200) begin
            if (bus.move_ack) acks++;
            n++;
            bus.move_req = (n == 10);
            step();
        end
        bus.move_req = 1'b0;
        if (bus.move_ack) acks++;
        total++;
        if (n !== 64 || acks !== 0) begin
            bad++; $display("FAIL prio_init busy=%0d acks=%0d required=64/0", n, acks);
        end
        total++;
        if ({sq(52), sq(44), sq(59), sq(3)} !== 16'b0001_0000_0101_1101) begin
            bad++; $display("FAIL prio_board actual=%b required=0001000001011101",
                            {sq(52), sq(44), sq(59), sq(3)});
        end
        step();
        total++;
        if (bus.busy !== 1'b0 || bus.move_ack !== 1'b0) begin
            bad++; $display("FAIL prio_dropped busy=%b ack=%b required=0/0", bus.busy, bus.move_ack);
        end
        snap = bus.board;
        bus.move_src = 6'd10;
        bus.move_dst = 6'd10;
        bus.move_req = 1'b1;
        step();
        bus.move_req = 1'b0;
        total++;
        if ({bus.move_ack, bus.busy, bus.done} !== 3'b110) begin
            bad++; $display("FAIL null_ack actual=%b required=110", {bus.move_ack, bus.busy, bus.done});
        end
        step();
        total++;
        if ({bus.move_ack, bus.busy, bus.done} !== 3'b001) begin
            bad++; $display("FAIL null_done actual=%b required=001", {bus.move_ack, bus.busy, bus.done});
        end
        total++;
        if (bus.board !== snap || bus.captured !== 4'b1101) begin
            bad++; $display("FAIL null_board changed=%b captured=%b required=0/1101",
                            (bus.board !== snap), bus.captured);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit done_seen;
        bus.init_req = 1'b1;
        step();
        bus.init_req = 1'b0;
        repeat (30) step();
        total++;
        if (bus.busy !== 1'b1 || sq(0) !== 4'b1100) begin
            bad++; $display("FAIL mid_running busy=%b sq0=%b required=1/1100", bus.busy, sq(0));
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.board !== 256'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL mid_reset_async board_nonzero=%b busy=%b required=0/0",
                            (bus.board !== 256'd0), bus.busy);
        end
        done_seen = bus.done;
        step();
        rst = 1'b0;
        repeat (70) begin
            step();
            if (bus.done || bus.busy) done_seen = 1'b1;
        end
        total++;
        if (done_seen !== 1'b0 || bus.board !== 256'd0) begin
            bad++; $display("FAIL mid_reset_after done_or_busy=%b board_nonzero=%b required=0/0",
                            done_seen, (bus.board !== 256'd0));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_init();
        test_move();
        test_capture();
        test_undo();
        test_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
